// File: rtl/enigma_pkg.sv
// Shared types, wiring tables, and letter arithmetic for the Enigma rotor/reflector datapath.
package enigma_pkg;

  localparam int unsigned NUM_LETTERS = 26;
  localparam int unsigned LW          = 5;
  localparam int unsigned TW          = 3;
  localparam int unsigned NUM_ROTORS  = 5;
  localparam int unsigned ROM_AW      = 9;
  localparam int unsigned ROM_DW      = 16;
  localparam int unsigned TBL_W       = 8 * NUM_LETTERS;

  typedef logic [LW-1:0] letter_t;
  typedef logic [TW-1:0] rotor_type_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_INV = 1'b1
  } rom_dir_e;

  // Wiring ROM address: {type, direction, letter}
  typedef struct packed {
    rotor_type_t rtype;
    rom_dir_e    dir;
    letter_t     letter;
  } rom_addr_t;

  // Value driven on letter outputs when the request was out of range
  localparam letter_t ERR_LETTER = '1;

  // Wiring tables as ASCII strings, leftmost character is position 0 (A)
  localparam logic [TBL_W-1:0] ROTOR_I     = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [TBL_W-1:0] ROTOR_II    = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [TBL_W-1:0] ROTOR_III   = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
  localparam logic [TBL_W-1:0] ROTOR_IV    = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [TBL_W-1:0] ROTOR_V     = "VZBRGITYUPSDNHLXAWMOQJFEKC";
  localparam logic [TBL_W-1:0] REFLECTOR_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  // Extract entry idx (0..25) of a table string as a letter index
  function automatic letter_t table_char(input logic [TBL_W-1:0] tbl, input letter_t idx);
    logic [7:0] ch;
    ch = tbl[8 * (NUM_LETTERS - 1 - 32'(idx)) +: 8];
    // 8'd65 is ASCII 'A'
    return LW'(ch - 8'd65);
  endfunction

  // Select the wiring string for rotors I..V
  function automatic logic [TBL_W-1:0] rotor_table(input rotor_type_t t);
    logic [TBL_W-1:0] tbl;
    case (t)
      3'd0:    tbl = ROTOR_I;
      3'd1:    tbl = ROTOR_II;
      3'd2:    tbl = ROTOR_III;
      3'd3:    tbl = ROTOR_IV;
      3'd4:    tbl = ROTOR_V;
      default: tbl = ROTOR_I;
    endcase
    return tbl;
  endfunction

  // Forward wiring; types 5..7 are identity
  function automatic letter_t wiring_fwd(input rotor_type_t t, input letter_t a);
    if ((32'(t) >= NUM_ROTORS) || (32'(a) >= NUM_LETTERS)) begin
      return a;
    end
    return table_char(rotor_table(t), a);
  endfunction

  // Inverse wiring found by searching the forward table
  function automatic letter_t wiring_inv(input rotor_type_t t, input letter_t x);
    letter_t r;
    r = x;
    if (32'(t) < NUM_ROTORS) begin
      for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
        if (wiring_fwd(t, LW'(i)) == x) begin
          r = LW'(i);
        end
      end
    end
    return r;
  endfunction

  // Reflector B lookup
  function automatic letter_t reflect_b(input letter_t x);
    if (32'(x) >= NUM_LETTERS) begin
      return '0;
    end
    return table_char(REFLECTOR_B, x);
  endfunction

  // (a + b) mod 26 with a single conditional subtract
  function automatic letter_t mod_add(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = 6'(a) + 6'(b);
    if (s >= 6'(NUM_LETTERS)) begin
      s = s - 6'(NUM_LETTERS);
    end
    return s[LW-1:0];
  endfunction

  // (a - b) mod 26, biased by +26 so the intermediate never goes negative
  function automatic letter_t mod_sub(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = 6'(a) + 6'(NUM_LETTERS) - 6'(b);
    if (s >= 6'(NUM_LETTERS)) begin
      s = s - 6'(NUM_LETTERS);
    end
    return s[LW-1:0];
  endfunction

  // Contents of one wiring ROM word
  function automatic logic [ROM_DW-1:0] rom_word(input rom_addr_t a);
    letter_t v;
    if (32'(a.letter) >= NUM_LETTERS) begin
      return '0;
    end
    if (a.dir == DIR_FWD) begin
      v = wiring_fwd(a.rtype, a.letter);
    end else begin
      v = wiring_inv(a.rtype, a.letter);
    end
    return ROM_DW'(v);
  endfunction

endpackage

// File: rtl/enigma_rotor_reflector_path_if.sv
// Request/result bundle between the Enigma datapath and its user.
interface enigma_rotor_reflector_path_if;
  import enigma_pkg::*;

  logic        in_valid;
  rotor_type_t rotor_type;
  letter_t     shift;
  letter_t     letter_in;
  logic        out_valid;
  letter_t     letter_out;
  letter_t     reflect_in;
  logic        out_err;

  modport master (
    output in_valid, rotor_type, shift, letter_in,
    input  out_valid, letter_out, reflect_in, out_err
  );

  modport slave (
    input  in_valid, rotor_type, shift, letter_in,
    output out_valid, letter_out, reflect_in, out_err
  );

endinterface

// File: rtl/enigma_wiring_rom.sv
// Dual-read-port combinational wiring ROM holding forward and inverse tables for all rotor types.
module enigma_wiring_rom
  import enigma_pkg::*;
(
  input  rom_addr_t         addr_a_i,
  input  rom_addr_t         addr_b_i,
  output logic [ROM_DW-1:0] data_a_c_o,
  output logic [ROM_DW-1:0] data_b_c_o
);

  logic [ROM_DW-1:0] rom_c [2**ROM_AW];

  // Every word is a constant computed from the package tables
  for (genvar k = 0; k < 2**ROM_AW; k++) begin : g_rom
    assign rom_c[k] = rom_word(rom_addr_t'(ROM_AW'(k)));
  end

  // Two independent read ports
  assign data_a_c_o = rom_c[ROM_AW'(addr_a_i)];
  assign data_b_c_o = rom_c[ROM_AW'(addr_b_i)];

endmodule

// File: rtl/enigma_rotor_reflector_path.sv
// Single-rotor Enigma path: rotor forward, reflector B, rotor backward; result registered.
module enigma_rotor_reflector_path
  import enigma_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  enigma_rotor_reflector_path_if.slave bus
);

  logic              in_err_c;
  letter_t           fwd_idx_c;
  letter_t           refl_in_c;
  letter_t           refl_out_c;
  letter_t           bwd_idx_c;
  letter_t           letter_c;
  rom_addr_t         fwd_addr_c;
  rom_addr_t         bwd_addr_c;
  logic [ROM_DW-1:0] fwd_word_c;
  logic [ROM_DW-1:0] bwd_word_c;
  logic              unused_rom_hi;

  logic    out_valid_d, out_valid_q;
  letter_t letter_out_d, letter_out_q;
  letter_t reflect_in_d, reflect_in_q;
  logic    out_err_d, out_err_q;

  enigma_wiring_rom u_rom (
    .addr_a_i   (fwd_addr_c),
    .addr_b_i   (bwd_addr_c),
    .data_a_c_o (fwd_word_c),
    .data_b_c_o (bwd_word_c)
  );

  // Only the letter field of each ROM word carries data
  assign unused_rom_hi = ^{fwd_word_c[ROM_DW-1:LW], bwd_word_c[ROM_DW-1:LW]};

  // Combinational letter path from the inputs to the output register
  always_comb begin
    in_err_c   = (32'(bus.letter_in) >= NUM_LETTERS) || (32'(bus.shift) >= NUM_LETTERS);
    fwd_idx_c  = mod_add(bus.letter_in, bus.shift);
    fwd_addr_c = '{rtype: bus.rotor_type, dir: DIR_FWD, letter: fwd_idx_c};
    refl_in_c  = mod_sub(fwd_word_c[LW-1:0], bus.shift);
    refl_out_c = reflect_b(refl_in_c);
    bwd_idx_c  = mod_add(refl_out_c, bus.shift);
    bwd_addr_c = '{rtype: bus.rotor_type, dir: DIR_INV, letter: bwd_idx_c};
    letter_c   = mod_sub(bwd_word_c[LW-1:0], bus.shift);
  end

  // Next-state of the result registers; hold when no request
  always_comb begin
    out_valid_d  = bus.in_valid;
    letter_out_d = letter_out_q;
    reflect_in_d = reflect_in_q;
    out_err_d    = out_err_q;
    if (bus.in_valid) begin
      if (in_err_c) begin
        letter_out_d = ERR_LETTER;
        reflect_in_d = ERR_LETTER;
        out_err_d    = 1'b1;
      end else begin
        letter_out_d = letter_c;
        reflect_in_d = refl_in_c;
        out_err_d    = 1'b0;
      end
    end
  end

  // Result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      letter_out_q <= '0;
      reflect_in_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      letter_out_q <= letter_out_d;
      reflect_in_q <= reflect_in_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.letter_out = letter_out_q;
  assign bus.reflect_in = reflect_in_q;
  assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_enigma_rotor_reflector_path.sv
// Bench for the single-rotor Enigma path: directed vector table, reset corners, full sweep.
module tb_enigma_rotor_reflector_path;

  logic clk;
  logic rst_n;

  enigma_rotor_reflector_path_if bus ();

  enigma_rotor_reflector_path dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  typedef struct {
    int rtype;
    int shift;
    int letter;
    int exp_refl;
    int exp_out;
    int exp_err;
  } vec_t;

  vec_t vecs[$];

  string rot_s [5];
  string refl_s;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_fwd(input int t, input int a);
    if (t > 4) return a;
    return int'(rot_s[t].getc(a)) - 65;
  endfunction

  function automatic int m_inv(input int t, input int x);
    int r;
    r = x;
    if (t <= 4) begin
      for (int i = 0; i < 26; i++) begin
        if (m_fwd(t, i) == x) r = i;
      end
    end
    return r;
  endfunction

  task automatic model(input int t, input int s, input int l, output int ri, output int lo);
    int a, f, r, b, g;
    a  = (l + s) % 26;
    f  = m_fwd(t, a);
    ri = (f - s + 26) % 26;
    r  = int'(refl_s.getc(ri)) - 65;
    b  = (r + s) % 26;
    g  = m_inv(t, b);
    lo = (g - s + 26) % 26;
  endtask

  task automatic drive(input int v, input int t, input int s, input int l);
    bus.in_valid   = (v != 0);
    bus.rotor_type = 3'(t);
    bus.shift      = 5'(s);
    bus.letter_in  = 5'(l);
  endtask

  initial begin
    int er, eo;
    int enc [26];

    n_vec  = 0;
    n_bad  = 0;
    rot_s[0] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    rot_s[1] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    rot_s[2] = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
    rot_s[3] = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
    rot_s[4] = "VZBRGITYUPSDNHLXAWMOQJFEKC";
    refl_s   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    //             type shift letter refl out err
    vecs.push_back('{3,  0,  3, 21, 24, 0});
    vecs.push_back('{3,  1,  3, 14, 15, 0});
    vecs.push_back('{3,  1, 19,  9,  7, 0});
    vecs.push_back('{3, 25, 25, 23, 12, 0});
    vecs.push_back('{3, 25, 22,  4,  5, 0});
    vecs.push_back('{3,  0, 26, 31, 31, 1});
    vecs.push_back('{0, 30,  0, 31, 31, 1});
    vecs.push_back('{6,  0,  0,  0, 24, 0});
    vecs.push_back('{7,  5,  2,  2, 20, 0});
    vecs.push_back('{2, 31, 31, 31, 31, 1});
    vecs.push_back('{0,  0,  0,  4,  7, 0});

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_out", int'(bus.letter_out), 0);
    check("reset_refl", int'(bus.reflect_in), 0);
    check("reset_err", int'(bus.out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: one request, then an idle cycle that must hold the data
    foreach (vecs[i]) begin
      drive(1, vecs[i].rtype, vecs[i].shift, vecs[i].letter);
      @(negedge clk);
      drive(0, 1, 9, 7);
      check($sformatf("vec%0d_valid", i), int'(bus.out_valid), 1);
      check($sformatf("vec%0d_out", i), int'(bus.letter_out), vecs[i].exp_out);
      check($sformatf("vec%0d_refl", i), int'(bus.reflect_in), vecs[i].exp_refl);
      check($sformatf("vec%0d_err", i), int'(bus.out_err), vecs[i].exp_err);
      @(negedge clk);
      check($sformatf("vec%0d_idle_valid", i), int'(bus.out_valid), 0);
      check($sformatf("vec%0d_hold_out", i), int'(bus.letter_out), vecs[i].exp_out);
      check($sformatf("vec%0d_hold_err", i), int'(bus.out_err), vecs[i].exp_err);
    end

    // Asynchronous reset in the middle of a stream
    drive(1, 3, 0, 3);
    @(negedge clk);
    drive(1, 3, 1, 3);
    check("pre_rst_out", int'(bus.letter_out), 24);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_out", int'(bus.letter_out), 0);
    check("async_rst_refl", int'(bus.reflect_in), 0);
    check("async_rst_err", int'(bus.out_err), 0);
    @(negedge clk);
    check("in_rst_valid", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    drive(0, 3, 1, 3);
    @(negedge clk);
    check("post_rst_idle_valid", int'(bus.out_valid), 0);
    check("post_rst_idle_out", int'(bus.letter_out), 0);
    drive(1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    check("post_rst_first_valid", int'(bus.out_valid), 1);
    check("post_rst_first_out", int'(bus.letter_out), 7);
    check("post_rst_first_refl", int'(bus.reflect_in), 4);
    @(negedge clk);

    // Back-to-back sweep with involution check
    for (int t = 0; t < 5; t++) begin
      for (int s = 0; s < 26; s++) begin
        for (int i = 0; i <= 26; i++) begin
          if (i > 0) begin
            model(t, s, i - 1, er, eo);
            check($sformatf("sweep_valid t%0d s%0d l%0d", t, s, i - 1), int'(bus.out_valid), 1);
            check($sformatf("sweep_out t%0d s%0d l%0d", t, s, i - 1), int'(bus.letter_out), eo);
            check($sformatf("sweep_refl t%0d s%0d l%0d", t, s, i - 1), int'(bus.reflect_in), er);
            check($sformatf("sweep_neq t%0d s%0d l%0d", t, s, i - 1),
                  int'(int'(bus.letter_out) != (i - 1)), 1);
            enc[i - 1] = int'(bus.letter_out);
          end
          if (i < 26) drive(1, t, s, i);
          else        drive(0, t, s, 0);
          @(negedge clk);
        end
        for (int i = 0; i <= 26; i++) begin
          if (i > 0) begin
            check($sformatf("reenc t%0d s%0d l%0d", t, s, i - 1), int'(bus.letter_out), i - 1);
          end
          if (i < 26) drive(1, t, s, enc[i] % 32);
          else        drive(0, t, s, 0);
          @(negedge clk);
        end
        check($sformatf("sweep_drain t%0d s%0d", t, s), int'(bus.out_valid), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
